// File: rtl/c_selector_n.sv
// c_selector_n: buffered N-way selector. One word plus a per-channel select mask
// is queued in a small FIFO. The head word is offered to every selected channel
// (or, in unicast mode, to the lowest selected one) and retires once all of them
// have taken it.
module c_selector_n #(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUT      = 6,
  parameter int BUF_DEPTH  = 2,
  parameter int MULTICAST  = 1,
  parameter int MASK_DATA  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_WIDTH+N_OUT-1:0]   i_data,
  output logic [N_OUT-1:0]              o_valid,
  input  logic [N_OUT-1:0]              i_ready,
  output logic [N_OUT*DATA_WIDTH-1:0]   o_data,
  output logic                          o_err,
  output logic [7:0]                    o_err_cnt,
  output logic                          o_busy
);

  // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_data [BUF_DEPTH];
  logic [N_OUT-1:0]      mem_mask [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_next;
  logic [CW-1:0]         count;
  logic [N_OUT-1:0]      r_pend;

  logic [N_OUT-1:0]      in_mask;
  logic [DATA_WIDTH-1:0] in_data;
  logic [N_OUT-1:0]      norm_mask;
  logic [N_OUT-1:0]      take;
  logic [N_OUT-1:0]      pend_left;
  logic [N_OUT-1:0]      next_head_mask;
  logic                  head_present;
  logic                  accept;
  logic                  push;
  logic                  zero_mask;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign in_mask   = i_data[DATA_WIDTH +: N_OUT];
  assign in_data   = i_data[DATA_WIDTH-1:0];
  // Unicast keeps only the lowest set bit (two's-complement isolate).
  assign norm_mask = (MULTICAST != 0) ? in_mask : (in_mask & (~in_mask + N_OUT'(1)));

  assign head_present = (count != '0);
  assign o_ready      = !rst && (count < CW'(BUF_DEPTH));
  assign accept       = i_valid && o_ready;
  assign push         = accept && (|in_mask);
  assign zero_mask    = accept && !(|in_mask);

  assign o_valid   = {N_OUT{head_present}} & r_pend;
  assign take      = o_valid & i_ready;
  assign pend_left = r_pend & ~take;
  assign pop       = head_present && (pend_left == '0);
  assign rd_next   = ptr_inc(rd_ptr);
  assign o_busy    = head_present;

  // Mask owed by the entry that becomes head right after a pop: the next stored
  // entry if one exists, otherwise a word being written at the same edge.
  always_comb begin
    next_head_mask = '0;
    if (count > CW'(1)) next_head_mask = mem_mask[rd_next];
    else if (push)      next_head_mask = norm_mask;
  end

  // Per-channel output slices, zeroed on idle channels when MASK_DATA is set.
  always_comb begin
    o_data = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if ((MASK_DATA != 0) && !o_valid[j]) o_data[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      else                                 o_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_data[rd_ptr];
    end
  end

  // FIFO storage, pointers, pending-channel mask and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_mask[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      r_pend    <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_mask[wr_ptr] <= norm_mask;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pop)                        r_pend <= next_head_mask;
      else if (!head_present && push) r_pend <= norm_mask;
      else                            r_pend <= pend_left;

      o_err <= zero_mask;
      if (zero_mask && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_c_selector_n.sv
// tb_c_selector_n: scoreboard bench for c_selector_n. Expected words are queued
// per channel when driven and compared when a channel handshake occurs.
module tb_c_selector_n;

  localparam int DW = 32;
  localparam int NO = 6;

  logic            clk = 1'b0;
  logic            rst;

  // Default (multicast) instance
  logic            i_valid;
  logic            o_ready;
  logic [DW+NO-1:0] i_data;
  logic [NO-1:0]   o_valid;
  logic [NO-1:0]   i_ready;
  logic [NO*DW-1:0] o_data;
  logic            o_err;
  logic [7:0]      o_err_cnt;
  logic            o_busy;

  // Unicast instance
  logic            u_valid;
  logic            u_ordy;
  logic [DW+NO-1:0] u_data;
  logic [NO-1:0]   u_ovalid;
  logic [NO-1:0]   u_rdy;
  logic [NO*DW-1:0] u_odata;
  logic            u_err;
  logic [7:0]      u_cnt;
  logic            u_busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] q [NO][$];

  c_selector_n #(.DATA_WIDTH(DW), .N_OUT(NO), .BUF_DEPTH(2), .MULTICAST(1), .MASK_DATA(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_err(o_err),
    .o_err_cnt(o_err_cnt), .o_busy(o_busy)
  );

  c_selector_n #(.DATA_WIDTH(DW), .N_OUT(NO), .BUF_DEPTH(2), .MULTICAST(0), .MASK_DATA(1)) dut_uni (
    .clk(clk), .rst(rst), .i_valid(u_valid), .o_ready(u_ordy), .i_data(u_data),
    .o_valid(u_ovalid), .i_ready(u_rdy), .o_data(u_odata), .o_err(u_err),
    .o_err_cnt(u_cnt), .o_busy(u_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NO-1:0] m, input logic [DW-1:0] p);
    int t = 0;
    i_valid = 1'b1;
    i_data  = {m, p};
    while (!o_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("push_timeout", o_ready, 1);
    else for (int j = 0; j < NO; j++) if (m[j]) q[j].push_back(p);
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (o_busy && t < 200) begin
      step();
      t++;
    end
    chk("drain_idle", o_busy, 0);
  endtask

  // Scoreboard monitor: checks each channel transfer against the owed word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NO; j++) begin
        if (o_valid[j]) begin
          chk("valid_owed", o_valid[j], q[j].size() != 0);
          if (i_ready[j] && q[j].size() != 0) begin
            logic [DW-1:0] e;
            e = q[j].pop_front();
            chk($sformatf("ch%0d_data", j), o_data[j*DW +: DW], e);
          end
        end else begin
          chk($sformatf("ch%0d_idle_zero", j), o_data[j*DW +: DW], 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NO*DW-1:0] e;
    logic [NO-1:0]    m;
    rst = 1'b1;
    i_valid = 1'b0; i_data = '0; i_ready = '0;
    u_valid = 1'b0; u_data = '0; u_rdy = '1;
    step();
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", o_err_cnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready_low", o_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", o_ready, 1);
    step();

    // Unicast: only the lowest mask bit is served
    u_valid = 1'b1;
    u_data  = {6'b001100, 32'hA5A5A5A5};
    step();
    u_valid = 1'b0;
    e = '0;
    e[2*DW +: DW] = 32'hA5A5A5A5;
    chk("uni_valid", u_ovalid, 6'b000100);
    chk("uni_data", u_odata, e);
    step();
    chk("uni_valid_gone", u_ovalid, 0);
    chk("uni_busy_gone", u_busy, 0);

    // Multicast with partial acceptance
    i_ready = 6'b000001;
    push(6'b101001, 32'h1234_5678);
    chk("mc_valid_c1", o_valid, 6'b101001);
    step();
    chk("mc_valid_c2", o_valid, 6'b101000);
    chk("mc_slice3_c2", o_data[3*DW +: DW], 32'h1234_5678);
    step();
    chk("mc_valid_c3", o_valid, 6'b101000);
    chk("mc_slice5_c3", o_data[5*DW +: DW], 32'h1234_5678);
    step();
    i_ready = '1;
    chk("mc_valid_c4", o_valid, 6'b101000);
    step();
    chk("mc_popped", o_valid, 0);
    chk("mc_idle", o_busy, 0);

    // Back-pressure and full
    i_ready = '0;
    push(6'b000011, 32'hAAAA_0001);
    push(6'b000110, 32'hAAAA_0002);
    chk("full_ready_low", o_ready, 0);
    chk("full_busy", o_busy, 1);
    i_valid = 1'b1;
    i_data  = {6'b001100, 32'hAAAA_0003};
    step();
    chk("full_held", o_ready, 0);
    chk("full_head", o_valid, 6'b000011);
    i_ready = '1;
    push(6'b001100, 32'hAAAA_0003);
    drain();

    // Zero masks: error pulses, saturating counter, nothing stored
    for (int k = 0; k < 300; k++) begin
      i_valid = 1'b1;
      i_data  = {6'b000000, DW'(k)};
      step();
      chk("zm_err", o_err, 1);
      chk("zm_cnt", o_err_cnt, (k + 1 > 255) ? 255 : k + 1);
      chk("zm_busy", o_busy, 0);
    end
    i_valid = 1'b0;
    step();
    chk("zm_err_clear", o_err, 0);
    chk("zm_cnt_hold", o_err_cnt, 255);

    // Full throughput streaming
    i_ready = '1;
    for (int k = 0; k < 16; k++) begin
      m = 6'b000001 << (k % 6);
      i_valid = 1'b1;
      i_data  = {m, 32'h5000_0000 + DW'(k)};
      chk("tp_ready", o_ready, 1);
      for (int j = 0; j < NO; j++) if (m[j]) q[j].push_back(32'h5000_0000 + DW'(k));
      step();
    end
    i_valid = 1'b0;
    chk("tp_last_head", o_busy, 1);
    step();
    chk("tp_no_backlog", o_busy, 0);

    // Reset during partial delivery
    i_ready = 6'b000001;
    push(6'b111111, 32'hDEAD_BEEF);
    chk("rm_valid", o_valid, 6'b111111);
    step();
    rst = 1'b1;
    i_ready = '0;
    #1;
    chk("rm_ready_in_rst", o_ready, 0);
    for (int j = 0; j < NO; j++) q[j].delete();
    step();
    chk("rm_valid_cleared", o_valid, 0);
    rst = 1'b0;
    #1;
    chk("rm_ready_after", o_ready, 1);
    chk("rm_busy_after", o_busy, 0);
    chk("rm_cnt_after", o_err_cnt, 0);
    i_ready = '1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rm_no_resend", o_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
